// File: rtl/mem_stage_pkg.sv
// Pipeline definitions shared by the execute, memory and writeback stages:
// load-op encodings, bus widths and the execute-to-memory payload layout.
package mem_stage_pkg;

    localparam int unsigned BUS_DATA_W  = 32;
    localparam int unsigned BUS_RADDR_W = 5;
    localparam int unsigned PC_W        = 32;
    localparam int unsigned LD_OP_W     = 3;

    localparam logic [LD_OP_W-1:0] LD_W  = 3'b000;
    localparam logic [LD_OP_W-1:0] LD_B  = 3'b001;
    localparam logic [LD_OP_W-1:0] LD_H  = 3'b010;
    localparam logic [LD_OP_W-1:0] LD_BU = 3'b101;
    localparam logic [LD_OP_W-1:0] LD_HU = 3'b110;

    // Instruction payload latched by the memory stage on accept
    typedef struct packed {
        logic [PC_W-1:0]        pc;
        logic                   rf_we;
        logic [BUS_RADDR_W-1:0] rf_waddr;
        logic [BUS_DATA_W-1:0]  alu_result;
        logic                   res_from_mem;
        logic [LD_OP_W-1:0]     ld_op;
    } es_to_ms_bus_t;

    localparam int unsigned ES_TO_MS_BUS_W = $bits(es_to_ms_bus_t);
    localparam int unsigned MS_TO_WS_BUS_W = PC_W + 1 + BUS_RADDR_W + BUS_DATA_W;

endpackage

// File: rtl/mem_stage_if.sv
// Execute-to-memory handshake and instruction payload.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                   es_to_ms_valid;
    logic                   ms_allowin;
    logic [PC_W-1:0]        es_pc;
    logic                   es_rf_we;
    logic [BUS_RADDR_W-1:0] es_rf_waddr;
    logic [BUS_DATA_W-1:0]  es_alu_result;
    logic                   es_res_from_mem;
    logic [LD_OP_W-1:0]     es_ld_op;

    modport master (
        output es_to_ms_valid, es_pc, es_rf_we, es_rf_waddr,
               es_alu_result, es_res_from_mem, es_ld_op,
        input  ms_allowin
    );

    modport slave (
        input  es_to_ms_valid, es_pc, es_rf_we, es_rf_waddr,
               es_alu_result, es_res_from_mem, es_ld_op,
        output ms_allowin
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Selects and extends the addressed byte/halfword of a loaded word.
// Unknown load ops return the full word.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [BUS_DATA_W-1:0] raw,
    input  logic [1:0]            addr,
    input  logic [LD_OP_W-1:0]    ld_op,
    output logic [BUS_DATA_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[7:0];
        case (addr)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
        // Halfword uses addr[1] only; misaligned accesses are not trapped here
        half_sel = addr[1] ? raw[31:16] : raw[15:0];
    end

    always_comb begin
        data = raw;
        case (ld_op)
            LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   data = {24'd0, byte_sel};
            LD_H:    data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   data = {16'd0, half_sel};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the instruction from execute, captures
// the 1-cycle-latency SRAM read data and forwards the result to writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ws_allowin,
    mem_stage_if.slave         es,
    input  logic [DATA_W-1:0]  data_sram_rdata,
    output logic               ms_to_ws_valid,
    output logic [PC_W-1:0]    ms_pc,
    output logic               ms_rf_we,
    output logic [RADDR_W-1:0] ms_rf_waddr,
    output logic [DATA_W-1:0]  ms_final_result,
    output logic               ms_res_from_mem
);

    logic                  ms_valid;
    logic                  ms_first;
    logic                  ms_ready_go;
    logic                  accept;
    es_to_ms_bus_t         ms_q;
    logic [BUS_DATA_W-1:0] rdata_hold;
    logic [BUS_DATA_W-1:0] raw_data;
    logic [BUS_DATA_W-1:0] load_data;

    assign ms_ready_go    = 1'b1;
    assign es.ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign accept         = es.es_to_ms_valid && es.ms_allowin;
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    // Stage state; payload holds across bubbles and stalls
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid   <= 1'b0;
            ms_first   <= 1'b0;
            rdata_hold <= '0;
            ms_q       <= '0;
        end else begin
            if (es.ms_allowin) begin
                ms_valid <= es.es_to_ms_valid;
            end
            ms_first <= accept;
            if (ms_first) begin
                rdata_hold <= BUS_DATA_W'(data_sram_rdata);
            end
            if (accept) begin
                ms_q.pc           <= es.es_pc;
                ms_q.rf_we        <= es.es_rf_we;
                ms_q.rf_waddr     <= es.es_rf_waddr;
                ms_q.alu_result   <= es.es_alu_result;
                ms_q.res_from_mem <= es.es_res_from_mem;
                ms_q.ld_op        <= es.es_ld_op;
            end
        end
    end

    // SRAM data is only trustworthy in the first cycle; later cycles use the held copy
    assign raw_data = ms_first ? BUS_DATA_W'(data_sram_rdata) : rdata_hold;

    mem_stage_load_align u_load_align (
        .raw   (raw_data),
        .addr  (ms_q.alu_result[1:0]),
        .ld_op (ms_q.ld_op),
        .data  (load_data)
    );

    assign ms_pc           = ms_q.pc;
    assign ms_rf_we        = ms_valid && ms_q.rf_we;
    assign ms_rf_waddr     = RADDR_W'(ms_q.rf_waddr);
    assign ms_res_from_mem = ms_valid && ms_q.res_from_mem;
    assign ms_final_result = DATA_W'(ms_q.res_from_mem ? load_data : ms_q.alu_result);

endmodule
